regfile_write_arbiter: RTL and testbench

//   Shares the single register-file write port between the pipeline writeback stage and the

---
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between writeback and multdiv
// Ports:
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   wb_we, wb_rd, wb_data            pipeline writeback request (never stalled)
//   md_done, md_rd, md_data          multdiv result, accepted when md_done && !md_stall
//   md_exception, md_is_div          multdiv exception flag and div/mult selector
//   md_stall, md_pending             holding FIFO full / holds at least one live entry
//   rf_we, rf_rd, rf_data            registered register-file write port
module regfile_write_arbiter #(
    parameter int DEPTH       = 2,
    parameter int RSTATUS_REG = 30,
    parameter int MUL_CODE    = 4,
    parameter int DIV_CODE    = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        md_done,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_exception,
    input  logic        md_is_div,
    output logic        md_stall,
    output logic        md_pending,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       entRd   [DEPTH];
    logic [31:0]      entData [DEPTH];
    logic [DEPTH-1:0] entValid;
    logic [PW-1:0]    rdPtr, wrPtr;
    logic [CW-1:0]    count;
    logic             mdAccept, wbGrant, fifoEmpty, headValid, popValid, popAny, bypass, push;
    logic [4:0]       xRd;
    logic [31:0]      xData;

    assign md_stall   = count == CW'(DEPTH);
    assign md_pending = |entValid;

    always_comb begin
        mdAccept  = md_done && !md_stall;
        xRd       = md_exception ? 5'(RSTATUS_REG) : md_rd;
        xData     = md_exception ? (md_is_div ? 32'(DIV_CODE) : 32'(MUL_CODE)) : md_data;
        wbGrant   = wb_we && wb_rd != 5'd0;
        fifoEmpty = count == '0;
        headValid = !fifoEmpty && entValid[rdPtr];
        popValid  = !wbGrant && headValid;
        // a squashed head leaves without using the port so the next entry is not delayed
        popAny    = !fifoEmpty && (popValid || !entValid[rdPtr]);
        bypass    = !wbGrant && fifoEmpty && mdAccept && xRd != 5'd0;
        // a same-cycle writeback to the same register is younger, so the md result is dropped
        push      = mdAccept && xRd != 5'd0 && !bypass && !(wbGrant && xRd == wb_rd);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entRd[wrPtr]   <= xRd;
            entData[wrPtr] <= xData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entValid <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_data  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wbGrant && entRd[i] == wb_rd) entValid[i] <= 1'b0;
            if (popAny) begin
                entValid[rdPtr] <= 1'b0;
                rdPtr           <= rdPtr + PW'(1);
            end
            if (push) begin
                entValid[wrPtr] <= 1'b1;
                wrPtr           <= wrPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(popAny);
            rf_we <= wbGrant || popValid || bypass;
            if (wbGrant) begin
                rf_rd   <= wb_rd;
                rf_data <= wb_data;
            end else if (popValid) begin
                rf_rd   <= entRd[rdPtr];
                rf_data <= entData[rdPtr];
            end else if (bypass) begin
                rf_rd   <= xRd;
                rf_data <= xData;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench for regfile_write_arbiter against a queue model
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        md_done = 1'b0;
    logic [4:0]  md_rd = '0;
    logic [31:0] md_data = '0;
    logic        md_exception = 1'b0;
    logic        md_is_div = 1'b0;
    logic        md_stall, md_pending, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .md_done(md_done), .md_rd(md_rd), .md_data(md_data),
        .md_exception(md_exception), .md_is_div(md_is_div),
        .md_stall(md_stall), .md_pending(md_pending),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    typedef struct { logic [4:0] rd; logic [31:0] data; bit valid; } entT;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wrT;

    entT mq[$];
    wrT  expq[$];
    int  tests = 0;
    int  fails = 0;
    bit  monEn = 1'b0;
    bit  lastAccept = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit anyValid();
        foreach (mq[i]) if (mq[i].valid) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: the FIFO is a queue of {rd,data,live}; each cycle at most one register write
    // is expected one edge later.
    function automatic void modelStep();
        logic [4:0]  xrd;
        logic [31:0] xdata;
        bit acc, grantWb, headOk, bypassed;
        if (reset) begin
            mq.delete();
            lastAccept = 1'b0;
            return;
        end
        acc      = md_done && mq.size() < DEPTH;
        xrd      = md_exception ? 5'd30 : md_rd;
        xdata    = md_exception ? (md_is_div ? 32'd5 : 32'd4) : md_data;
        grantWb  = wb_we && wb_rd != 5'd0;
        headOk   = mq.size() > 0 && mq[0].valid;
        bypassed = 1'b0;
        if (grantWb) begin
            expq.push_back(wrT'{wb_rd, wb_data});
            foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].valid = 1'b0;
        end else if (headOk) begin
            expq.push_back(wrT'{mq[0].rd, mq[0].data});
        end else if (mq.size() == 0 && acc && xrd != 5'd0) begin
            expq.push_back(wrT'{xrd, xdata});
            bypassed = 1'b1;
        end
        if (mq.size() > 0 && (!headOk || !grantWb)) void'(mq.pop_front());
        if (acc && xrd != 5'd0 && !bypassed && !(grantWb && xrd == wb_rd))
            mq.push_back(entT'{xrd, xdata, 1'b1});
        lastAccept = acc;
    endfunction

    task automatic drive(bit rst, bit we, logic [4:0] wrd, logic [31:0] wd, bit md,
                         logic [4:0] mrd, logic [31:0] mdat, bit exc, bit div);
        @(negedge clock);
        reset = rst; wb_we = we; wb_rd = wrd; wb_data = wd;
        md_done = md; md_rd = mrd; md_data = mdat; md_exception = exc; md_is_div = div;
        modelStep();
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    endtask

    task automatic afterEdge();
        @(posedge clock);
        #2;
    endtask

    always @(posedge clock) begin : monitor
        wrT e;
        #1;
        if (monEn) begin
            chk("md_stall", md_stall, mq.size() == DEPTH);
            chk("md_pending", md_pending, anyValid());
            if (rf_we === 1'b1) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", rf_rd, rf_data);
                end else begin
                    e = expq.pop_front();
                    chk("rf_rd", rf_rd, e.rd);
                    chk("rf_data", rf_data, e.data);
                end
            end else begin
                chk("rf_we", rf_we, expq.size() != 0);
                if (expq.size() != 0) void'(expq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mdIdx;
        drive(1, 1, 5'd3, 32'h5, 1, 5'd4, 32'h6, 0, 0);
        monEn = 1'b1;
        drive(1, 1, 5'd3, 32'h5, 1, 5'd4, 32'h6, 0, 0);
        idle();
        afterEdge();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_md_stall", md_stall, 0);
        chk("reset_md_pending", md_pending, 0);
        chk("reset_rf_rd", rf_rd, 0);
        chk("reset_rf_data", rf_data, 0);

        drive(0, 0, 5'd0, 32'd0, 1, 5'd8, 32'h1234, 0, 0);
        afterEdge();
        chk("bypass_we", rf_we, 1);
        chk("bypass_rd", rf_rd, 8);
        chk("bypass_data", rf_data, 32'h1234);

        drive(0, 1, 5'd3, 32'hA, 1, 5'd9, 32'hB, 0, 0);
        afterEdge();
        chk("collide_wb_rd", rf_rd, 3);
        chk("collide_wb_data", rf_data, 32'hA);
        idle();
        afterEdge();
        chk("collide_md_rd", rf_rd, 9);
        chk("collide_md_data", rf_data, 32'hB);

        mdIdx = 10;
        for (int c = 0; c < 8; c++) begin
            drive(0, c < 4, 5'(c + 1), 32'h100 + c, mdIdx <= 12, 5'(mdIdx), 32'h200 + mdIdx, 0, 0);
            if (lastAccept) mdIdx++;
            afterEdge();
            if (c == 1) chk("stall_after_two", md_stall, 1);
            if (c == 3) chk("third_held", mdIdx, 12);
        end
        chk("all_three_accepted", mdIdx, 13);

        drive(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h99, 1, 1);
        afterEdge();
        chk("div_exc_rd", rf_rd, 30);
        chk("div_exc_data", rf_data, 5);
        drive(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h99, 1, 0);
        afterEdge();
        chk("mul_exc_data", rf_data, 4);

        drive(0, 1, 5'd5, 32'h55, 1, 5'd12, 32'h66, 0, 0);
        afterEdge();
        chk("queued_pending", md_pending, 1);
        drive(0, 1, 5'd12, 32'h77, 0, 5'd0, 32'd0, 0, 0);
        afterEdge();
        chk("squash_rd", rf_rd, 12);
        chk("squash_data", rf_data, 32'h77);
        chk("squash_pending", md_pending, 0);
        idle();
        afterEdge();
        chk("squash_no_write", rf_we, 0);

        for (int n = 0; n < 3000; n++)
            drive($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                  $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));

        for (int n = 0; n < 4; n++) idle();
        @(posedge clock);
        #3;
        chk("drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
